ysyx_22050550_div_ctrl: RTL
===========================

# ysyx_22050550_div_ctrl

Issue/retire controller between the EXU dispatch point and the iterative divider (`ysyx_22050550_Diver`). It accepts one RV64M divide/remainder op (DIV/DIVU/REM/REMU and the W forms), resolves divide-by-zero and signed overflow locally, and otherwise runs the divider through its handshake. It captures the one-cycle divider result, selects quotient or remainder, sign-extends W results, and holds the value until writeback accepts it.

## Interface
- No parameters.
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- io_Id_Valid  in  1  op request
- io_Id_Ready  out  1  controller can accept; high only in IDLE
- io_Id_Op  in  2  [1] 0 = div, 1 = rem; [0] 0 = signed, 1 = unsigned (funct3[1:0])
- io_Id_Word  in  1  W-form op
- io_Id_Src1 / io_Id_Src2  in  64  dividend / divisor
- io_Id_Rd  in  5  destination register
- io_Flush  in  1  kill the in-flight op, same cycle
- io_Div_Valid / io_Div_Flush / io_Div_Divw  out  1  to divider
- io_Div_Signed  out  2  2'b11 = signed, 2'b00 = unsigned
- io_Div_Dividend / io_Div_Divisor  out  64  to divider
- io_Div_Ready / io_Div_OutValid  in  1  from divider
- io_Div_Quotient / io_Div_Remainder  in  64  from divider
- io_Wb_Valid  out  1  result valid
- io_Wb_Ready  in  1  writeback accepts
- io_Wb_Data  out  64  result
- io_Wb_Rd  out  5  destination register

## Operation
- States: IDLE, ISSUE, DONE.
- Accept: io_Id_Valid & io_Id_Ready & !io_Flush.
  - Latch the op, word flag, rd and operands into holding registers.
  - W ops store low 32 bits of each operand, sign-extended when signed and zero-extended when unsigned.
- Special cases are decided at accept from the raw 32/64-bit operand width.
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed with dividend = most-negative and divisor = -1: quotient = dividend; remainder = 0.
  - Either special case goes IDLE -> DONE directly; the divider is never touched.
- Otherwise go IDLE -> ISSUE.
- Divider drive: operands, Divw and Signed come straight from the holding registers and stay stable for the whole of ISSUE. The divider's outputs depend combinationally on these.
- io_Div_Valid = (state == ISSUE) & !(io_Flush & io_Div_Ready).
  - It stays high every ISSUE cycle, including the io_Div_OutValid cycle. The divider advances only while Valid is high and must leave its Valid state.
- On io_Div_OutValid in ISSUE:
  - Capture the quotient (div) or remainder (rem) into the result register.
  - W ops replace bits [63:32] with bit 31.
  - Go to DONE.
- DONE: io_Wb_Valid = 1 with io_Wb_Data/io_Wb_Rd held. io_Wb_Ready -> IDLE.
- Flush, which has priority over every other transition:
  - IDLE: the request is not accepted.
  - ISSUE with io_Div_Ready = 1: Div_Valid is 0; go to IDLE.
  - ISSUE with divider busy (io_Div_Ready = 0, io_Div_OutValid = 0): io_Div_Flush = 1 and io_Div_Valid = 1 for that cycle; go to IDLE.
  - ISSUE on the io_Div_OutValid cycle: Div_Valid stays 1 (the divider returns to Idle); the result is discarded; go to IDLE.
  - DONE: drop the result; go to IDLE.
- io_Div_Flush = io_Flush & (state == ISSUE) & !io_Div_Ready & !io_Div_OutValid.

## Timing
- Reset values:
  - State IDLE; io_Id_Ready = 1.
  - io_Wb_Valid, io_Div_Valid and io_Div_Flush = 0.
  - Holding registers, io_Wb_Data and io_Wb_Rd = 0.
- Accept at cycle T, 64-bit op:
  - ISSUE from T+1, with Div_Valid high from T+1.
  - Divider Busy T+2..T+65; OutValid at T+66.
  - io_Wb_Valid from T+67.
- Accept at cycle T, W op: OutValid at T+34; io_Wb_Valid from T+35.
- Accept at cycle T, special case: io_Wb_Valid at T+1.
- io_Id_Ready is low from T+1 until the cycle after the Wb handshake or flush. There is no back-to-back accept in the handshake cycle.
- Wb handshake at cycle W: io_Wb_Valid = 0 and io_Id_Ready = 1 at W+1.
- Reset mid-operation returns everything to IDLE in the next cycle. The divider shares the reset.

## Test plan
- DIVU 100 / 7 -> io_Wb_Data = 14 at T+67; REMU with the same operands -> 2.
- REM -7 / 2 (signed) -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIV -> 0xFFFF_FFFF_FFFF_FFFD (-3).
- DIV x / 0 -> all ones at T+1; REMU 0x1234 / 0 -> 0x1234.
- Signed overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
  - DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
- DIVW with src1 = 0xDEAD_BEEF_FFFF_FFF0 (-16) and src2 = 0x1234_5678_0000_0004 (4) -> 0xFFFF_FFFF_FFFF_FFFC at T+35.
- Flush at T+20 of a 64-bit op:
  - io_Div_Flush pulses once; IDLE at T+21; io_Div_Ready = 1 at T+22.
  - A new DIVU 9 / 3 then returns 3.
- Writeback backpressure: hold io_Wb_Ready = 0 for 10 cycles -> io_Wb_Data stays stable and io_Id_Ready stays 0 throughout.

Source files
------------

// File: rtl/ysyx_22050550_div_ctrl.sv
// Issue/retire controller between EXU dispatch and the iterative divider:
// resolves divide-by-zero and signed overflow locally, otherwise runs the divider handshake.
module ysyx_22050550_div_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_Id_Valid,
  output logic        io_Id_Ready,
  input  logic [1:0]  io_Id_Op,
  input  logic        io_Id_Word,
  input  logic [63:0] io_Id_Src1,
  input  logic [63:0] io_Id_Src2,
  input  logic [4:0]  io_Id_Rd,
  input  logic        io_Flush,
  output logic        io_Div_Valid,
  output logic        io_Div_Flush,
  output logic        io_Div_Divw,
  output logic [1:0]  io_Div_Signed,
  output logic [63:0] io_Div_Dividend,
  output logic [63:0] io_Div_Divisor,
  input  logic        io_Div_Ready,
  input  logic        io_Div_OutValid,
  input  logic [63:0] io_Div_Quotient,
  input  logic [63:0] io_Div_Remainder,
  output logic        io_Wb_Valid,
  input  logic        io_Wb_Ready,
  output logic [63:0] io_Wb_Data,
  output logic [4:0]  io_Wb_Rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // W ops keep only the low word, extended according to signedness
  function automatic logic signed [63:0] ext_operand(input logic [63:0] v,
                                                     input logic word,
                                                     input logic uns);
    logic signed [63:0] r;
    if (!word)    r = $signed(v);
    else if (uns) r = $signed({32'h0, v[31:0]});
    else          r = $signed({{32{v[31]}}, v[31:0]});
    return r;
  endfunction

  function automatic logic signed [63:0] sext_word(input logic signed [63:0] v,
                                                   input logic word);
    logic signed [63:0] r;
    r = word ? $signed({{32{v[31]}}, v[31:0]}) : v;
    return r;
  endfunction

  // holding registers
  logic               rem_q;
  logic               uns_q;
  logic               word_q;
  logic [4:0]         rd_q;
  logic signed [63:0] dividend_q;
  logic signed [63:0] divisor_q;
  logic signed [63:0] result_q;

  logic               accept;
  logic               is_rem_in;
  logic               is_uns_in;
  logic signed [63:0] src1_ext;
  logic signed [63:0] src2_ext;
  logic               divisor_zero;
  logic               signed_ovf;
  logic               special;
  logic signed [63:0] special_res;
  logic signed [63:0] div_sel;
  logic signed [63:0] div_res;
  logic               div_capture;

  assign is_rem_in = io_Id_Op[1];
  assign is_uns_in = io_Id_Op[0];
  assign src1_ext  = ext_operand(io_Id_Src1, io_Id_Word, is_uns_in);
  assign src2_ext  = ext_operand(io_Id_Src2, io_Id_Word, is_uns_in);

  assign io_Id_Ready = (state == IDLE);
  assign accept      = io_Id_Valid & io_Id_Ready & !io_Flush;

  // Special cases judged on the raw operand width, not the extended value
  assign divisor_zero = io_Id_Word ? (io_Id_Src2[31:0] == 32'h0)
                                   : (io_Id_Src2 == 64'h0);
  assign signed_ovf   = !is_uns_in &
                        (io_Id_Word ? ((io_Id_Src1[31:0] == 32'h8000_0000) &&
                                       (io_Id_Src2[31:0] == 32'hFFFF_FFFF))
                                    : ((io_Id_Src1 == 64'h8000_0000_0000_0000) &&
                                       (io_Id_Src2 == 64'hFFFF_FFFF_FFFF_FFFF)));
  assign special      = divisor_zero | signed_ovf;

  always_comb begin
    special_res = '0;
    if (divisor_zero)
      special_res = is_rem_in ? src1_ext : '1;
    else if (signed_ovf)
      special_res = is_rem_in ? '0 : src1_ext;
    special_res = sext_word(special_res, io_Id_Word);
  end

  assign div_sel     = rem_q ? $signed(io_Div_Remainder) : $signed(io_Div_Quotient);
  assign div_res     = sext_word(div_sel, word_q);
  assign div_capture = (state == ISSUE) & io_Div_OutValid & !io_Flush;

  // stage boundary: state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : ISSUE;
      ISSUE:   if (io_Flush) state_nxt = IDLE;
               else if (io_Div_OutValid) state_nxt = DONE;
      DONE:    if (io_Flush || io_Wb_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stage boundary: operand holding and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q      <= 1'b0;
      uns_q      <= 1'b0;
      word_q     <= 1'b0;
      rd_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        rem_q      <= is_rem_in;
        uns_q      <= is_uns_in;
        word_q     <= io_Id_Word;
        rd_q       <= io_Id_Rd;
        dividend_q <= src1_ext;
        divisor_q  <= src2_ext;
        if (special) result_q <= special_res;
      end
      if (div_capture) result_q <= div_res;
    end
  end

  // Valid stays high on OutValid so the divider can leave its result state
  assign io_Div_Valid    = (state == ISSUE) & !(io_Flush & io_Div_Ready);
  assign io_Div_Flush    = io_Flush & (state == ISSUE) & !io_Div_Ready & !io_Div_OutValid;
  assign io_Div_Divw     = word_q;
  assign io_Div_Signed   = uns_q ? 2'b00 : 2'b11;
  assign io_Div_Dividend = dividend_q;
  assign io_Div_Divisor  = divisor_q;

  assign io_Wb_Valid = (state == DONE);
  assign io_Wb_Data  = result_q;
  assign io_Wb_Rd    = rd_q;

endmodule
